// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, Z/C flag register and iterative or barrel shifter.
// Define ALU_SEQ_OVF_EN to add the registered signed-overflow flag output ovf.
module alu_seq #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SERIAL_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_shift,
    input  logic             upd_zc,
    input  logic [1:0]       scode,
    input  logic [2:0]       acode,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
`ifdef ALU_SEQ_OVF_EN
    output logic             carry,
    output logic             ovf
`else
    output logic             carry
`endif
);

    localparam int unsigned SW     = $clog2(WIDTH);
    localparam int          MaxAmt = (1 << SW) - 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_shift;
    logic [1:0]       r_scode;
    logic [2:0]       r_acode;
    logic             r_upd;
    logic             r_cin;
    logic [SW-1:0]    r_cnt;
    logic             r_sc;
    logic [WIDTH-1:0] r_res;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [WIDTH-1:0] w_bop;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [WIDTH-1:0] w_bsh_val;
    logic             w_bsh_c;
    logic [WIDTH:0]   w_step;
    logic             w_amt_zero;
    logic             w_exec_done;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
    logic             w_fin_v;

    // Returns {bit shifted/rotated out, new value} for a single-bit step.
    function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v, input logic [1:0] code);
        logic [WIDTH:0] res;
        unique case (code)
            2'b00:   res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            2'b01:   res = {v[0], 1'b0, v[WIDTH-1:1]};
            2'b10:   res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: res = {v[0], v[0], v[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    // Subtracts add the inverted operand; ADC/SBC take the carry captured at accept.
    always_comb begin
        w_bop   = r_acode[1] ? ~r_b : r_b;
        w_cin   = r_acode[0] ? r_cin : r_acode[1];
        w_sum   = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (r_acode)
            3'b100:  w_alu_res = r_a & r_b;
            3'b101:  w_alu_res = r_a | r_b;
            3'b110:  w_alu_res = r_a ^ r_b;
            3'b111:  w_alu_res = r_b;
            default: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (r_a[WIDTH-1] ^ w_sum[WIDTH-1]) & (w_bop[WIDTH-1] ^ w_sum[WIDTH-1]);
            end
        endcase
    end

    always_comb begin
        w_bsh_val = r_a;
        w_bsh_c   = 1'b0;
        for (int i = 0; i < MaxAmt; i++) begin
            if (SW'(i) < r_b[SW-1:0]) begin
                {w_bsh_c, w_bsh_val} = f_step(w_bsh_val, r_scode);
            end
        end
    end

    always_comb begin
        w_step      = f_step(r_a, r_scode);
        w_amt_zero  = (r_b[SW-1:0] == '0);
        w_exec_done = !r_shift || (SERIAL_SHIFT == 0) || (r_cnt == '0);
        w_fin_v     = 1'b0;
        if (r_shift) begin
            w_fin_res = (SERIAL_SHIFT != 0) ? r_a : w_bsh_val;
            if (w_amt_zero) begin
                w_fin_c = r_c;
            end else begin
                w_fin_c = (SERIAL_SHIFT != 0) ? r_sc : w_bsh_c;
            end
        end else begin
            w_fin_res = w_alu_res;
            w_fin_c   = w_alu_c;
            w_fin_v   = w_alu_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_shift     <= 1'b0;
            r_scode     <= 2'b00;
            r_acode     <= 3'b000;
            r_upd       <= 1'b0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_sc        <= 1'b0;
            r_res       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_shift    <= is_shift;
                        r_scode    <= scode;
                        r_acode    <= acode;
                        r_upd      <= upd_zc;
                        r_cin      <= r_c;
                        r_cnt      <= b[SW-1:0];
                        r_sc       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= StExec;
                    end
                end
                StExec: begin
                    if (w_exec_done) begin
                        r_res       <= w_fin_res;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                        if (r_upd) begin
                            r_z <= (w_fin_res == '0);
                            r_c <= w_fin_c;
                            r_v <= w_fin_v;
                        end
                    end else begin
                        r_a   <= w_step[WIDTH-1:0];
                        r_sc  <= w_step[WIDTH];
                        r_cnt <= r_cnt - SW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Clear overrides any commit scheduled above in the same cycle.
            if (flag_clr) begin
                r_z <= 1'b0;
                r_c <= 1'b0;
                r_v <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign r         = r_res;
    assign zero      = r_z;
    assign carry     = r_c;
`ifdef ALU_SEQ_OVF_EN
    assign ovf       = r_v;
`else
    logic w_unused_v;
    assign w_unused_v = r_v;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, serial shifter) with an arithmetic reference model.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SS = 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_shift;
    logic         upd_zc;
    logic [1:0]   scode;
    logic [2:0]   acode;
    logic         flag_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         zero;
    logic         carry;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    int m_z   = 0;
    int m_c   = 0;
    int m_v   = 0;

    alu_seq #(.WIDTH(W), .SERIAL_SHIFT(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_shift  (is_shift),
        .upd_zc    (upd_zc),
        .scode     (scode),
        .acode     (acode),
        .flag_clr  (flag_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zero      (zero),
`ifdef ALU_SEQ_OVF_EN
        .carry     (carry),
        .ovf       (ovf)
`else
        .carry     (carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_zero"}, int'(zero), m_z);
        chk({tag, "_carry"}, int'(carry), m_c);
`ifdef ALU_SEQ_OVF_EN
        chk({tag, "_ovf"}, int'(ovf), m_v);
`endif
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: result, candidate carry/overflow and expected latency from the op definition.
    task automatic model(input int ia, input int ib, input int sh, input int code, input int cin,
                         output int res, output int c, output int v, output int lat);
        int n, s, sv;
        v = 0;
        if (sh != 0) begin
            n   = ib % 8;
            lat = (SS != 0) ? n + 1 : 1;
            if (n == 0) begin
                res = ia;
                c   = cin;
            end else begin
                case (code)
                    0: begin res = (ia << n) % 256; c = (ia >> (W - n)) % 2; end
                    1: begin res = ia >> n; c = (ia >> (n - 1)) % 2; end
                    2: begin res = ((ia << n) | (ia >> (W - n))) % 256; c = res % 2; end
                    default: begin
                        res = ((ia >> n) | (ia << (W - n))) % 256;
                        c   = res / 128;
                    end
                endcase
            end
        end else begin
            lat = 1;
            c   = 0;
            case (code)
                0: begin s = ia + ib;             sv = sgn(ia) + sgn(ib); end
                1: begin s = ia + ib + cin;       sv = sgn(ia) + sgn(ib) + cin; end
                2: begin s = ia + 255 - ib + 1;   sv = sgn(ia) - sgn(ib); end
                3: begin s = ia + 255 - ib + cin; sv = sgn(ia) - sgn(ib) - 1 + cin; end
                4: s = ia & ib;
                5: s = ia | ib;
                6: s = ia ^ ib;
                default: s = ib;
            endcase
            res = s % 256;
            if (code < 4) begin
                c = s / 256;
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
        end
    endtask

    task automatic run_op(input string tag, input int ia, input int ib, input int sh,
                          input int code, input int upd, input int hold);
        int res, c, v, lat, cnt;
        model(ia, ib, sh, code, m_c, res, c, v, lat);
        a        = W'(ia);
        b        = W'(ib);
        is_shift = sh[0];
        scode    = code[1:0];
        acode    = code[2:0];
        upd_zc   = upd[0];
        in_valid = 1'b1;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, lat);
        if (upd != 0) begin
            m_z = (res == 0) ? 1 : 0;
            m_c = c;
            m_v = v;
        end
        chk({tag, "_r"}, int'(r), res);
        chk_flags(tag);
        if (hold != 0) begin
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                a = W'($urandom_range(0, 255));
                @(posedge clk); #1;
                chk({tag, "_hold_r"}, int'(r), res);
                chk({tag, "_hold_valid"}, int'(out_valid), 1);
                chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
                chk_flags({tag, "_hold"});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_idle_in_ready"}, int'(in_ready), 1);
        chk({tag, "_idle_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_shift = 1'b0; upd_zc = 1'b0;
        scode = 2'b00; acode = 3'b000; flag_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_r", int'(r), 0);
        chk_flags("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add", 'hE5, 'h07, 0, 0, 1, 0);
        run_op("sub_eq", 'h07, 'h07, 0, 2, 1, 0);
        run_op("adc_noupd", 'h01, 'h01, 0, 1, 0, 0);
        run_op("shl6", 'hE5, 'h06, 1, 0, 1, 0);
        run_op("ror3", 'hE5, 'h03, 1, 3, 1, 0);
        run_op("sh0", 'hE5, 'h00, 1, 2, 1, 0);
        run_op("backpressure", 'h3C, 'h0F, 0, 6, 1, 5);

        // Reset in the middle of a 6-bit serial shift.
        run_op("setc", 'hFF, 'h01, 0, 0, 1, 0);
        a = 8'hE5; b = 8'h06; is_shift = 1'b1; scode = 2'b00; upd_zc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_z = 0; m_c = 0; m_v = 0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk_flags("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("add_after_rst", 'h12, 'h34, 0, 0, 1, 0);

        // flag_clr during the cycle that enters DONE wins over the commit.
        run_op("setc2", 'hF0, 'h20, 0, 0, 1, 0);
        a = 8'hFF; b = 8'h02; is_shift = 1'b0; acode = 3'b000; upd_zc = 1'b1; in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        m_z = 0; m_c = 0; m_v = 0;
        chk("clr_valid", int'(out_valid), 1);
        chk("clr_r", int'(r), 'h01);
        chk_flags("clr");
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("clr_idle", int'(in_ready), 1);

`ifdef ALU_SEQ_OVF_EN
        run_op("ovf_add", 'h7F, 'h01, 0, 0, 1, 0);
        run_op("ovf_sub", 'h80, 'h01, 0, 2, 1, 0);
        run_op("ovf_and", 'hFF, 'h80, 0, 4, 1, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            int sh;
            sh = int'($urandom_range(0, 1));
            run_op("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), sh,
                   int'($urandom_range(0, (sh != 0) ? 3 : 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        cnt = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
